// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with a fixed clocks-per-bit
// sample count, mid-bit start validation and stop-bit framing check.
module uart_receiver #(
    parameter int CLKs_Per_Bit = 87,
    parameter bit MSB_FIRST    = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_dv,
    output logic       o_frame_err,
    output logic       o_rx_active
);

    localparam int unsigned CW = $clog2(CLKs_Per_Bit) + 1;
    localparam logic [CW-1:0] HALF = CW'((CLKs_Per_Bit - 1) / 2);
    localparam logic [CW-1:0] LAST = CW'(CLKs_Per_Bit - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_hist;

    logic            w_bit;
    logic            w_fall;
    logic [7:0]      w_shift_next;

    assign w_bit  = r_sync2;
    assign w_fall = r_hist & ~r_sync2;

    // Two-stage synchronizer plus history flop for falling-edge detection; idle-high reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_hist  <= 1'b1;
        end else begin
            r_sync1 <= i_rx_serial;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    // Place the newly sampled bit so the first received bit lands at bit 7 or bit 0
    always_comb begin
        w_shift_next = r_shift;
        if (MSB_FIRST) begin
            w_shift_next = {r_shift[6:0], w_bit};
        end else begin
            w_shift_next = {w_bit, r_shift[7:1]};
        end
    end

    // Receive FSM: start validation at mid-bit, 8 data samples, stop check, registered strobes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            o_rx_byte   <= '0;
            o_rx_dv     <= 1'b0;
            o_frame_err <= 1'b0;
            o_rx_active <= 1'b0;
        end else begin
            o_rx_dv     <= 1'b0;
            o_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_count   <= '0;
                    r_bit_idx <= '0;
                    if (w_fall) begin
                        r_state     <= START;
                        o_rx_active <= 1'b1;
                    end
                end
                START: begin
                    if (r_count == HALF) begin
                        r_count <= '0;
                        if (!w_bit) begin
                            r_state <= DATA;
                        end else begin
                            r_state     <= IDLE;
                            o_rx_active <= 1'b0;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                DATA: begin
                    if (r_count == LAST) begin
                        r_count <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit_idx == 3'd7) begin
                            r_bit_idx <= '0;
                            r_state   <= STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                STOP: begin
                    if (r_count == LAST) begin
                        r_count     <= '0;
                        r_state     <= IDLE;
                        o_rx_active <= 1'b0;
                        if (w_bit) begin
                            o_rx_byte <= r_shift;
                            o_rx_dv   <= 1'b1;
                        end else begin
                            o_frame_err <= 1'b1;
                        end
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a timing/byte reference model.
module tb_uart_receiver;

    localparam int CPB   = 87;
    localparam int CPB16 = 16;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rx   = 1'b1;
    logic rx16 = 1'b1;

    logic [7:0] byte_m, byte_l, byte_h;
    logic       dv_m, dv_l, dv_h;
    logic       fe_m, fe_l, fe_h;
    logic       act_m, act_l, act_h;

    int cyc = 0;
    int tests_run = 0;
    int tests_failed = 0;
    int overlap = 0;

    int         dv_cyc[$];
    logic [7:0] dv_byte[$];
    int         fe_cyc[$];
    int         l_cyc[$];
    logic [7:0] l_byte[$];
    int         h_cyc[$];
    logic [7:0] h_byte[$];
    int         exp_cyc[$];
    logic [7:0] exp_byte[$];
    logic [7:0] exp_hbyte[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(.CLKs_Per_Bit(CPB), .MSB_FIRST(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(rx),
        .o_rx_byte(byte_m), .o_rx_dv(dv_m), .o_frame_err(fe_m), .o_rx_active(act_m)
    );

    uart_receiver #(.CLKs_Per_Bit(CPB16), .MSB_FIRST(1'b0)) dut_lsb (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(rx16),
        .o_rx_byte(byte_l), .o_rx_dv(dv_l), .o_frame_err(fe_l), .o_rx_active(act_l)
    );

    uart_receiver #(.CLKs_Per_Bit(CPB16), .MSB_FIRST(1'b1)) dut_msb (
        .i_clk(clk), .i_rst(rst), .i_rx_serial(rx16),
        .o_rx_byte(byte_h), .o_rx_dv(dv_h), .o_frame_err(fe_h), .o_rx_active(act_h)
    );

    // Event recorder: every strobe cycle is logged with the edge count it followed
    always @(negedge clk) begin
        if (dv_m) begin dv_cyc.push_back(cyc); dv_byte.push_back(byte_m); end
        if (fe_m) fe_cyc.push_back(cyc);
        if (dv_l) begin l_cyc.push_back(cyc); l_byte.push_back(byte_l); end
        if (dv_h) begin h_cyc.push_back(cyc); h_byte.push_back(byte_h); end
        if ((dv_m && fe_m) || (dv_l && fe_l) || (dv_h && fe_h)) overlap++;
    end

    // Reference model: line bit k is lb[k]; MSB-first puts it at byte bit 7-k
    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Line drops at the negedge where cyc == c; first edge to see it is c+1,
    // the synchronizer puts E0 at c+3; stop sampled at E0 + (HALF+1) + 9*cpb.
    function automatic int strobe_time(input int c, input int cpb);
        return c + 3 + (cpb - 1) / 2 + 1 + 9 * cpb;
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx = v; else rx16 = v;
    endtask

    task automatic drive_frame(input int which, input int cpb, input logic [7:0] lb,
                               input logic stopv, input int stop_len, output int c);
        c = cyc;
        set_line(which, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            set_line(which, lb[k]);
            repeat (cpb) @(negedge clk);
        end
        set_line(which, stopv);
        repeat (stop_len) @(negedge clk);
    endtask

    task automatic clear_q();
        dv_cyc.delete(); dv_byte.delete(); fe_cyc.delete();
        l_cyc.delete(); l_byte.delete(); h_cyc.delete(); h_byte.delete();
        exp_cyc.delete(); exp_byte.delete(); exp_hbyte.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; rx = 1'b1; rx16 = 1'b1;
        repeat (5) @(negedge clk);
        tests_run++; if (byte_m !== 8'h00) begin tests_failed++; $display("FAIL reset_byte got %h want 00", byte_m); end
        tests_run++; if (dv_m !== 1'b0) begin tests_failed++; $display("FAIL reset_dv got %b want 0", dv_m); end
        tests_run++; if (fe_m !== 1'b0) begin tests_failed++; $display("FAIL reset_fe got %b want 0", fe_m); end
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL reset_active got %b want 0", act_m); end
        tests_run++; if (byte_l !== 8'h00 || byte_h !== 8'h00) begin tests_failed++; $display("FAIL reset_byte16 got %h/%h want 00/00", byte_l, byte_h); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL idle_active got %b want 0", act_m); end
    endtask

    task automatic test_frame_a5();
        int c;
        clear_q();
        drive_frame(0, CPB, rev8(8'hA5), 1'b1, CPB, c);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 1) begin tests_failed++; $display("FAIL a5_dv_count got %0d want 1", dv_cyc.size()); end
        if (dv_cyc.size() >= 1) begin
            tests_run++; if (dv_cyc[0] !== strobe_time(c, CPB)) begin tests_failed++; $display("FAIL a5_dv_time got %0d want %0d", dv_cyc[0], strobe_time(c, CPB)); end
            tests_run++; if (dv_byte[0] !== 8'hA5) begin tests_failed++; $display("FAIL a5_byte got %h want a5", dv_byte[0]); end
        end
        tests_run++; if (fe_cyc.size() !== 0) begin tests_failed++; $display("FAIL a5_fe_count got %0d want 0", fe_cyc.size()); end
        tests_run++; if (byte_m !== 8'hA5) begin tests_failed++; $display("FAIL a5_held got %h want a5", byte_m); end
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL a5_active_after got %b want 0", act_m); end
    endtask

    task automatic test_glitch();
        int c;
        logic [7:0] prev;
        clear_q();
        prev = byte_m;
        c = cyc;
        rx = 1'b0;
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        tests_run++; if (act_m !== 1'b1) begin tests_failed++; $display("FAIL glitch_active_mid got %b want 1 at %0d", act_m, cyc - c); end
        repeat (16) @(negedge clk);
        tests_run++; if (act_m !== 1'b1) begin tests_failed++; $display("FAIL glitch_active_late got %b want 1 at %0d", act_m, cyc - c); end
        repeat (2) @(negedge clk);
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL glitch_active_drop got %b want 0 at %0d", act_m, cyc - c); end
        repeat (200) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 0 || fe_cyc.size() !== 0) begin tests_failed++; $display("FAIL glitch_strobes got dv=%0d fe=%0d want 0/0", dv_cyc.size(), fe_cyc.size()); end
        tests_run++; if (byte_m !== prev) begin tests_failed++; $display("FAIL glitch_byte got %h want %h", byte_m, prev); end
    endtask

    task automatic test_frame_err();
        int c;
        logic [7:0] prev;
        logic [7:0] d;
        clear_q();
        prev = byte_m;
        drive_frame(0, CPB, rev8(8'h3C), 1'b0, CPB, c);
        repeat (2000) @(negedge clk);
        tests_run++; if (fe_cyc.size() !== 1) begin tests_failed++; $display("FAIL ferr_count got %0d want 1", fe_cyc.size()); end
        if (fe_cyc.size() >= 1) begin
            tests_run++; if (fe_cyc[0] !== strobe_time(c, CPB)) begin tests_failed++; $display("FAIL ferr_time got %0d want %0d", fe_cyc[0], strobe_time(c, CPB)); end
        end
        tests_run++; if (dv_cyc.size() !== 0) begin tests_failed++; $display("FAIL ferr_dv got %0d want 0", dv_cyc.size()); end
        tests_run++; if (byte_m !== prev) begin tests_failed++; $display("FAIL ferr_byte got %h want %h", byte_m, prev); end
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL ferr_low_line_active got %b want 0", act_m); end
        rx = 1'b1;
        repeat (20) @(negedge clk);
        clear_q();
        d = 8'($urandom);
        drive_frame(0, CPB, rev8(d), 1'b1, CPB, c);
        repeat (30) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 1 || fe_cyc.size() !== 0) begin tests_failed++; $display("FAIL ferr_recover got dv=%0d fe=%0d want 1/0", dv_cyc.size(), fe_cyc.size()); end
        tests_run++; if (byte_m !== d) begin tests_failed++; $display("FAIL ferr_recover_byte got %h want %h", byte_m, d); end
    endtask

    task automatic test_random_frames();
        int c;
        int gap;
        int stop_len;
        logic [7:0] d;
        clear_q();
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            gap = $urandom_range(0, 40);
            stop_len = $urandom_range(48, 130);
            rx = 1'b1;
            repeat (gap) @(negedge clk);
            drive_frame(0, CPB, rev8(d), 1'b1, stop_len, c);
            exp_cyc.push_back(strobe_time(c, CPB));
            exp_byte.push_back(d);
        end
        rx = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== exp_cyc.size()) begin tests_failed++; $display("FAIL rand_count got %0d want %0d", dv_cyc.size(), exp_cyc.size()); end
        for (int i = 0; i < exp_cyc.size() && i < dv_cyc.size(); i++) begin
            tests_run++; if (dv_cyc[i] !== exp_cyc[i]) begin tests_failed++; $display("FAIL rand_time[%0d] got %0d want %0d", i, dv_cyc[i], exp_cyc[i]); end
            tests_run++; if (dv_byte[i] !== exp_byte[i]) begin tests_failed++; $display("FAIL rand_byte[%0d] got %h want %h", i, dv_byte[i], exp_byte[i]); end
        end
        tests_run++; if (fe_cyc.size() !== 0) begin tests_failed++; $display("FAIL rand_fe got %0d want 0", fe_cyc.size()); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, diff;
        clear_q();
        drive_frame(0, CPB, rev8(8'h3C), 1'b1, CPB, c1);
        drive_frame(0, CPB, rev8(8'hC3), 1'b1, CPB, c2);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 2) begin tests_failed++; $display("FAIL b2b_count got %0d want 2", dv_cyc.size()); end
        if (dv_cyc.size() >= 2) begin
            diff = dv_cyc[1] - dv_cyc[0];
            tests_run++; if (diff < 869 || diff > 871) begin tests_failed++; $display("FAIL b2b_spacing got %0d want 870+-1", diff); end
            tests_run++; if (dv_byte[0] !== 8'h3C || dv_byte[1] !== 8'hC3) begin tests_failed++; $display("FAIL b2b_bytes got %h,%h want 3c,c3", dv_byte[0], dv_byte[1]); end
        end
    endtask

    task automatic test_reset_mid();
        int c;
        logic [7:0] lb;
        clear_q();
        lb = rev8(8'h6B);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            rx = lb[k];
            repeat (CPB) @(negedge clk);
        end
        rx = lb[4];
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (byte_m !== 8'h00) begin tests_failed++; $display("FAIL rstmid_byte got %h want 00", byte_m); end
        tests_run++; if (act_m !== 1'b0) begin tests_failed++; $display("FAIL rstmid_active got %b want 0", act_m); end
        rx = 1'b1;
        repeat (1000) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 0 || fe_cyc.size() !== 0) begin tests_failed++; $display("FAIL rstmid_strobes got dv=%0d fe=%0d want 0/0", dv_cyc.size(), fe_cyc.size()); end
        drive_frame(0, CPB, rev8(8'h5A), 1'b1, CPB, c);
        repeat (30) @(negedge clk);
        tests_run++; if (dv_cyc.size() !== 1) begin tests_failed++; $display("FAIL rstmid_next_count got %0d want 1", dv_cyc.size()); end
        tests_run++; if (byte_m !== 8'h5A) begin tests_failed++; $display("FAIL rstmid_next_byte got %h want 5a", byte_m); end
    endtask

    task automatic test_bit_order();
        int c;
        int c_first;
        logic [7:0] lb;
        clear_q();
        c_first = 0;
        for (int i = 0; i < 5; i++) begin
            lb = (i == 0) ? 8'h01 : 8'($urandom);
            rx16 = 1'b1;
            repeat ($urandom_range(0, 10)) @(negedge clk);
            drive_frame(1, CPB16, lb, 1'b1, CPB16, c);
            if (i == 0) c_first = c;
            exp_cyc.push_back(strobe_time(c, CPB16));
            exp_byte.push_back(lb);
            exp_hbyte.push_back(rev8(lb));
        end
        rx16 = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++; if (l_cyc.size() !== 5 || h_cyc.size() !== 5) begin tests_failed++; $display("FAIL order_count got %0d/%0d want 5/5", l_cyc.size(), h_cyc.size()); end
        if (l_cyc.size() >= 1 && h_cyc.size() >= 1) begin
            tests_run++; if (l_cyc[0] !== c_first + 3 + 8 + 144) begin tests_failed++; $display("FAIL order_time got %0d want %0d", l_cyc[0], c_first + 155); end
            tests_run++; if (l_byte[0] !== 8'h01) begin tests_failed++; $display("FAIL order_lsb_first got %h want 01", l_byte[0]); end
            tests_run++; if (h_byte[0] !== 8'h80) begin tests_failed++; $display("FAIL order_msb_first got %h want 80", h_byte[0]); end
        end
        for (int i = 1; i < exp_cyc.size() && i < l_cyc.size() && i < h_cyc.size(); i++) begin
            tests_run++; if (l_cyc[i] !== exp_cyc[i] || h_cyc[i] !== exp_cyc[i]) begin tests_failed++; $display("FAIL order_time[%0d] got %0d/%0d want %0d", i, l_cyc[i], h_cyc[i], exp_cyc[i]); end
            tests_run++; if (l_byte[i] !== exp_byte[i]) begin tests_failed++; $display("FAIL order_lsb[%0d] got %h want %h", i, l_byte[i], exp_byte[i]); end
            tests_run++; if (h_byte[i] !== exp_hbyte[i]) begin tests_failed++; $display("FAIL order_msb[%0d] got %h want %h", i, h_byte[i], exp_hbyte[i]); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_random_frames();
        test_back_to_back();
        test_reset_mid();
        test_bit_order();
        tests_run++; if (overlap !== 0) begin tests_failed++; $display("FAIL dv_fe_overlap got %0d want 0", overlap); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
